// File: rtl/cms_pkg.sv
// Shared definitions for the trace packetizer: control address map,
// mode register bit positions and the trigger FSM state encoding.
package cms_pkg;

  // Control bus address map
  localparam int CMS_ADDR_MODE       = 'h00;
  localparam int CMS_ADDR_TLAST      = 'h01;
  localparam int CMS_ADDR_START_PC   = 'h02;
  localparam int CMS_ADDR_STOP_PC    = 'h03;
  localparam int CMS_ADDR_DROP_CLR   = 'h04;
  localparam int CMS_ADDR_EVSEL_BASE = 'h10;

  // Bit positions inside the mode register
  localparam int CMS_MODE_CAPTURE_EN = 0;
  localparam int CMS_MODE_TRIGGER_EN = 1;
  localparam int CMS_MODE_DELTA      = 2;

  typedef enum logic [1:0] {
    CMS_IDLE    = 2'd0,
    CMS_ARMED   = 2'd1,
    CMS_RUNNING = 2'd2
  } cms_state_e;

endpackage

// File: rtl/cms_pkt_fifo.sv
// Synchronous packet FIFO.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (clears contents)
//   push_i, din_i    write request and data; ignored when full unless a pop
//                    happens in the same cycle
//   pop_i            read request; ignored when empty
//   dout_o           head entry, taken straight from the storage flops
//   full_o, empty_o  occupancy flags
module cms_pkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cms_pkt_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cms_trace_packetizer.sv
// Trace packetizer: captures retired (pc, instr) with a free-running cycle
// stamp and NUM_COUNTERS event counters, buffers the packets and streams
// them out as AXI-Stream beats.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   instr, pc, pc_valid, en          retire tap and global enable
//   performance_events               one-cycle event pulses
//   ctrl_addr/wdata/write_enable     control bus, acts on write-enable rise
//   M_AXIS_tvalid/tready/tdata/tlast packet stream
//   drop_count                       saturating count of dropped packets
//   dbg_state                        trigger FSM state (cms_state_e encoding)
//
// Stream handshake: a beat transfers on a cycle where tvalid && tready;
// tvalid never drops and tdata/tlast never change while tvalid && !tready.
module cms_trace_packetizer
  import cms_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int NUM_EVENTS      = 115,
  parameter int NUM_COUNTERS    = 8,
  parameter int COUNTER_WIDTH   = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int AXI_DATA_WIDTH  = 1024,
  parameter int CTRL_ADDR_WIDTH = 8,
  parameter int CTRL_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                instr,
  input  logic [XLEN-1:0]            pc,
  input  logic                       pc_valid,
  input  logic                       en,
  input  logic [NUM_EVENTS-1:0]      performance_events,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  input  logic                       ctrl_write_enable,
  output logic                       M_AXIS_tvalid,
  input  logic                       M_AXIS_tready,
  output logic [AXI_DATA_WIDTH-1:0]  M_AXIS_tdata,
  output logic                       M_AXIS_tlast,
  output logic [31:0]                drop_count,
  output logic [1:0]                 dbg_state
);
  localparam int CNT_LSB  = XLEN + 32 + 64;
  localparam int PKT_W    = CNT_LSB + NUM_COUNTERS * COUNTER_WIDTH + 1;
  localparam int EV_IDX_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

  if (AXI_DATA_WIDTH < PKT_W) begin : g_bad_width
    $error("cms_trace_packetizer: AXI_DATA_WIDTH too small for packet");
  end

  logic                       we_q;
  logic [2:0]                 mode_q;
  logic [31:0]                tlast_interval_q;
  logic [XLEN-1:0]            start_pc_q;
  logic [XLEN-1:0]            stop_pc_q;
  logic [CTRL_DATA_WIDTH-1:0] evsel_q [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0]   cnt_q   [NUM_COUNTERS];
  logic [63:0]                clk_count_q;
  logic [31:0]                drop_count_q;
  logic                       ovf_pending_q;
  logic [31:0]                beat_cnt_q;
  logic [31:0]                cur_interval_q;
  cms_state_e                 state_q;
  cms_state_e                 state_d;

  logic                    wr_take;
  logic                    capture_en;
  logic                    trigger_en;
  logic                    delta_mode;
  logic                    retire;
  logic                    stop_hit;
  logic                    capture;
  logic                    push_ok;
  logic                    beat_done;
  logic [NUM_COUNTERS-1:0] ev_hit;
  logic [PKT_W-1:0]        pkt;
  logic [PKT_W-1:0]        fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign wr_take    = ctrl_write_enable && !we_q;
  assign capture_en = mode_q[CMS_MODE_CAPTURE_EN];
  assign trigger_en = mode_q[CMS_MODE_TRIGGER_EN];
  assign delta_mode = mode_q[CMS_MODE_DELTA];
  assign retire     = pc_valid && en;

  // Trigger next state; capture uses it so the start_pc instruction itself
  // is captured, and stop_hit lets the stop_pc instruction through as well.
  always_comb begin
    state_d  = state_q;
    stop_hit = 1'b0;
    if (!capture_en) begin
      state_d = CMS_IDLE;
    end else if (retire) begin
      case (state_q)
        CMS_IDLE:    state_d = trigger_en ? CMS_ARMED : CMS_RUNNING;
        CMS_ARMED:   if (pc == start_pc_q) state_d = CMS_RUNNING;
        CMS_RUNNING: if (trigger_en && pc == stop_pc_q) begin
                       state_d  = CMS_ARMED;
                       stop_hit = 1'b1;
                     end
        default:     state_d = CMS_IDLE;
      endcase
    end
  end

  assign capture   = retire && (state_d == CMS_RUNNING || stop_hit);
  assign beat_done = M_AXIS_tvalid && M_AXIS_tready;
  assign push_ok   = capture && (!fifo_full || beat_done);

  // Selects at or beyond NUM_EVENTS never count.
  always_comb begin
    ev_hit = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (en && evsel_q[i] < CTRL_DATA_WIDTH'(NUM_EVENTS))
        ev_hit[i] = performance_events[evsel_q[i][EV_IDX_W-1:0]];
    end
  end

  always_comb begin
    pkt = '0;
    pkt[XLEN-1:0]         = pc;
    pkt[XLEN +: 32]       = instr;
    pkt[XLEN + 32 +: 64]  = clk_count_q;
    for (int i = 0; i < NUM_COUNTERS; i++)
      pkt[CNT_LSB + i*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_q[i];
    pkt[PKT_W-1]          = ovf_pending_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q             <= 1'b0;
      mode_q           <= '0;
      tlast_interval_q <= 32'd1;
      start_pc_q       <= '0;
      stop_pc_q        <= '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        evsel_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      clk_count_q      <= '0;
      drop_count_q     <= '0;
      ovf_pending_q    <= 1'b0;
      beat_cnt_q       <= '0;
      cur_interval_q   <= 32'd1;
      state_q          <= CMS_IDLE;
    end else begin
      we_q        <= ctrl_write_enable;
      clk_count_q <= clk_count_q + 64'd1;
      state_q     <= state_d;

      if (wr_take) begin
        if (ctrl_addr == CTRL_ADDR_WIDTH'(CMS_ADDR_MODE))
          mode_q <= ctrl_wdata[2:0];
        if (ctrl_addr == CTRL_ADDR_WIDTH'(CMS_ADDR_TLAST))
          tlast_interval_q <= (ctrl_wdata[31:0] == 32'd0) ? 32'd1 : ctrl_wdata[31:0];
        if (ctrl_addr == CTRL_ADDR_WIDTH'(CMS_ADDR_START_PC))
          start_pc_q <= XLEN'(ctrl_wdata);
        if (ctrl_addr == CTRL_ADDR_WIDTH'(CMS_ADDR_STOP_PC))
          stop_pc_q <= XLEN'(ctrl_wdata);
      end
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (wr_take && ctrl_addr == CTRL_ADDR_WIDTH'(CMS_ADDR_EVSEL_BASE + i))
          evsel_q[i] <= ctrl_wdata;
      end

      if (wr_take && ctrl_addr == CTRL_ADDR_WIDTH'(CMS_ADDR_DROP_CLR))
        drop_count_q <= '0;
      else if (capture && !push_ok && drop_count_q != '1)
        drop_count_q <= drop_count_q + 32'd1;

      if (capture && !push_ok) ovf_pending_q <= 1'b1;
      else if (push_ok)        ovf_pending_q <= 1'b0;

      // Delta restart only on an accepted packet: a dropped capture keeps
      // the accumulated counts for the next packet.
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (push_ok && delta_mode)
          cnt_q[i] <= COUNTER_WIDTH'(ev_hit[i]);
        else if (ev_hit[i] && cnt_q[i] != '1)
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end

      if (beat_done)
        beat_cnt_q <= M_AXIS_tlast ? 32'd0 : beat_cnt_q + 32'd1;
      // The interval for the presented beat is frozen so tlast stays stable
      // during a stall; a new interval applies from the next beat.
      if (beat_done || !M_AXIS_tvalid)
        cur_interval_q <= tlast_interval_q;
    end
  end

  cms_pkt_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_ok),
    .din_i   (pkt),
    .pop_i   (beat_done),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign M_AXIS_tvalid = !fifo_empty;
  assign M_AXIS_tdata  = AXI_DATA_WIDTH'(fifo_dout);
  // >= keeps the burst bounded if the interval shrank below the beat count.
  assign M_AXIS_tlast  = M_AXIS_tvalid && (beat_cnt_q + 32'd1 >= cur_interval_q);
  assign drop_count    = drop_count_q;
  assign dbg_state     = state_q;

endmodule
